// File: rtl/cardinal_pkg.sv
// Constants shared between the processor control and the branch predictor.
// Also provides the 2-bit saturating counter step used by the PHT.
package cardinal_pkg;

    localparam logic [5:0] BRANCH_EZ = 6'b100010;
    localparam logic [5:0] BRANCH_NZ = 6'b100011;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        result = ctr;
        if (taken && ctr != CTR_MAX)
            result = ctr + 2'd1;
        else if (!taken && ctr != CTR_MIN)
            result = ctr - 2'd1;
        return result;
    endfunction

endpackage

// File: rtl/bp_pattern_table.sv
// Pattern history table: 2^IDX_W two-bit saturating counters.
// Lookup is asynchronous, so a same-cycle update to the same entry reads the old value.
module bp_pattern_table
    import cardinal_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic [1:0]       lookup_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr [2**IDX_W];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 2**IDX_W; i++)
                ctr[i] <= CTR_RESET;
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_step(ctr[upd_idx], upd_taken);
        end
    end

    assign lookup_ctr = ctr[lookup_idx];

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare predictor for the IF stage: PC xor global history indexes the PHT,
// training and history repair happen when ID resolves the branch one cycle later.
module gshare_branch_predictor
    import cardinal_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int GHR_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [0:7]       IF_PC,
    input  logic [0:31]      IF_Instr,
    input  logic             IF_Hold,
    output logic             Prediction,
    input  logic             Res_Valid,
    input  logic             Res_Taken,
    output logic             Mispredict,
    output logic [0:CNT_W-1] Branch_Count,
    output logic [0:CNT_W-1] Mispredict_Count
);

    logic [GHR_W-1:0] ghr;
    logic [GHR_W-1:0] rec_ghr;
    logic             rec_v;
    logic             rec_pred;
    logic [IDX_W-1:0] rec_idx;
    logic [IDX_W-1:0] idx;
    logic [1:0]       ctr;
    logic             is_br;
    logic             eff_res;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;
    logic             unused_bits;

    assign unused_bits = ^{IF_PC, IF_Instr[6:31]};

    assign is_br   = (IF_Instr[0:5] == BRANCH_EZ) || (IF_Instr[0:5] == BRANCH_NZ);
    assign idx     = IF_PC[8-IDX_W:7] ^ IDX_W'(ghr);

    assign Prediction = is_br & ctr[1];
    assign eff_res    = Res_Valid & rec_v & ~IF_Hold;
    assign Mispredict = eff_res & (Res_Taken != rec_pred);

    bp_pattern_table #(
        .IDX_W(IDX_W)
    ) u_pht (
        .Clock      (Clock),
        .Reset      (Reset),
        .lookup_idx (idx),
        .lookup_ctr (ctr),
        .upd_en     (eff_res),
        .upd_idx    (rec_idx),
        .upd_taken  (Res_Taken)
    );

    // A mispredict squashes the IF instruction and rebuilds history from the checkpoint.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ghr      <= '0;
            rec_v    <= 1'b0;
            rec_pred <= 1'b0;
            rec_idx  <= '0;
            rec_ghr  <= '0;
            br_cnt   <= '0;
            mis_cnt  <= '0;
        end else if (!IF_Hold) begin
            rec_v    <= is_br & ~Mispredict;
            rec_idx  <= idx;
            rec_pred <= Prediction;
            rec_ghr  <= ghr;
            if (Mispredict)
                ghr <= GHR_W'({rec_ghr, Res_Taken});
            else if (is_br)
                ghr <= GHR_W'({ghr, Prediction});
            if (eff_res && !(&br_cnt))
                br_cnt <= br_cnt + CNT_W'(1);
            if (Mispredict && !(&mis_cnt))
                mis_cnt <= mis_cnt + CNT_W'(1);
        end
    end

    assign Branch_Count     = br_cnt;
    assign Mispredict_Count = mis_cnt;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Randomized bench for the gshare predictor against an array/integer model,
// with directed sequences whose outcomes are pinned by hand-computed literals.
module tb_gshare_branch_predictor;

    localparam int IDX_W = 6;
    localparam int GHR_W = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clock;
    logic             Reset;
    logic [0:7]       IF_PC;
    logic [0:31]      IF_Instr;
    logic             IF_Hold;
    logic             Prediction;
    logic             Res_Valid;
    logic             Res_Taken;
    logic             Mispredict;
    logic [0:CNT_W-1] Branch_Count;
    logic [0:CNT_W-1] Mispredict_Count;

    gshare_branch_predictor #(
        .IDX_W(IDX_W),
        .GHR_W(GHR_W),
        .CNT_W(CNT_W)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .IF_PC            (IF_PC),
        .IF_Instr         (IF_Instr),
        .IF_Hold          (IF_Hold),
        .Prediction       (Prediction),
        .Res_Valid        (Res_Valid),
        .Res_Taken        (Res_Taken),
        .Mispredict       (Mispredict),
        .Branch_Count     (Branch_Count),
        .Mispredict_Count (Mispredict_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model state, kept as plain integers.
    int m_pht [1 << IDX_W];
    int m_ghr;
    int m_rec_v;
    int m_rec_idx;
    int m_rec_pred;
    int m_rec_ghr;
    int m_bc;
    int m_mc;
    int started;

    int n_checks;
    int n_fail;

    logic [31:0] s_pred, s_mis, s_bc, s_mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < (1 << IDX_W); i++) m_pht[i] = 1;
        m_ghr = 0; m_rec_v = 0; m_rec_idx = 0; m_rec_pred = 0; m_rec_ghr = 0;
        m_bc = 0; m_mc = 0;
    endtask

    // One clock cycle: inputs are already driven; compare, then advance the model at the edge.
    task automatic tick();
        int op, is_br, idx, m_pred, eff, m_mis, old_ghr;
        #3;
        op     = int'(IF_Instr[0:5]);
        is_br  = (op == 34 || op == 35) ? 1 : 0;
        idx    = (int'(IF_PC) % (1 << IDX_W)) ^ m_ghr;
        m_pred = (is_br != 0 && m_pht[idx] >= 2) ? 1 : 0;
        eff    = (Res_Valid && m_rec_v != 0 && !IF_Hold) ? 1 : 0;
        m_mis  = (eff != 0 && int'(Res_Taken) != m_rec_pred) ? 1 : 0;
        s_pred = 32'(Prediction);
        s_mis  = 32'(Mispredict);
        s_bc   = 32'(Branch_Count);
        s_mc   = 32'(Mispredict_Count);
        if (started != 0) begin
            chk("prediction", s_pred, 32'(m_pred));
            chk("mispredict", s_mis, 32'(m_mis));
            chk("branch_count", s_bc, 32'(m_bc));
            chk("mispredict_count", s_mc, 32'(m_mc));
        end
        @(posedge Clock);
        if (Reset) begin
            model_reset();
            started = 1;
        end else if (!IF_Hold) begin
            old_ghr = m_ghr;
            if (eff != 0) begin
                if (Res_Taken) m_pht[m_rec_idx] = (m_pht[m_rec_idx] < 3) ? m_pht[m_rec_idx] + 1 : 3;
                else           m_pht[m_rec_idx] = (m_pht[m_rec_idx] > 0) ? m_pht[m_rec_idx] - 1 : 0;
                if (m_bc < CNT_MAX) m_bc++;
                if (m_mis != 0 && m_mc < CNT_MAX) m_mc++;
            end
            if (m_mis != 0) begin
                m_ghr   = ((m_rec_ghr << 1) | int'(Res_Taken)) % (1 << GHR_W);
                m_rec_v = 0;
            end else begin
                if (is_br != 0) m_ghr = ((m_ghr << 1) | m_pred) % (1 << GHR_W);
                m_rec_v = is_br;
            end
            m_rec_idx  = idx;
            m_rec_pred = m_pred;
            m_rec_ghr  = old_ghr;
        end
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input int pc, input logic rv, input logic rt, input logic hold);
        IF_Instr  = {op, 26'd0};
        IF_PC     = 8'(pc);
        Res_Valid = rv;
        Res_Taken = rt;
        IF_Hold   = hold;
    endtask

    localparam logic [5:0] OP_BEZ  = 6'b100010;
    localparam logic [5:0] OP_BNEZ = 6'b100011;
    localparam logic [5:0] OP_NOP  = 6'b000000;

    initial begin
        logic [5:0] op;
        n_checks = 0; n_fail = 0; started = 0;
        model_reset();
        Reset = 1'b1;
        drive(OP_NOP, 0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        Reset = 1'b0;

        // Cold branch after reset
        drive(OP_BEZ, 'h10, 1'b0, 1'b0, 1'b0); tick();
        chk("cold_pred", s_pred, 0);
        chk("cold_bc", s_bc, 0);
        chk("cold_mc", s_mc, 0);
        drive(OP_NOP, 0, 1'b0, 1'b0, 1'b0); tick();

        // Training: history moves the index, so the third fetch lands on the trained entry 0x11
        drive(OP_BNEZ, 'h10, 1'b0, 1'b0, 1'b0); tick();
        chk("train_pred1", s_pred, 0);
        drive(OP_NOP, 0, 1'b1, 1'b1, 1'b0); tick();
        chk("train_mis1", s_mis, 1);
        drive(OP_BNEZ, 'h10, 1'b0, 1'b0, 1'b0); tick();
        chk("train_pred2", s_pred, 0);
        drive(OP_NOP, 0, 1'b1, 1'b1, 1'b0); tick();
        chk("train_mis2", s_mis, 1);
        drive(OP_BNEZ, 'h12, 1'b0, 1'b0, 1'b0); tick();
        chk("train_pred3", s_pred, 1);
        drive(OP_NOP, 0, 1'b1, 1'b1, 1'b0); tick();
        chk("train_mis3", s_mis, 0);
        drive(OP_NOP, 0, 1'b0, 1'b0, 1'b0); tick();
        chk("train_bc", s_bc, 3);
        chk("train_mc", s_mc, 2);
        chk("model_ghr_after_train", 32'(m_ghr), 7);

        // Mispredict flush with a younger branch in IF
        drive(OP_BNEZ, 'h16, 1'b0, 1'b0, 1'b0); tick();
        chk("flush_pred_old", s_pred, 1);
        drive(OP_BEZ, 'h00, 1'b1, 1'b0, 1'b0); tick();
        chk("flush_mis", s_mis, 1);
        chk("model_ghr_repaired", 32'(m_ghr), 14);
        drive(OP_NOP, 0, 1'b1, 1'b1, 1'b0); tick();
        chk("flush_young_ignored", s_mis, 0);
        drive(OP_NOP, 0, 1'b0, 1'b0, 1'b0); tick();
        chk("flush_bc", s_bc, 4);
        chk("flush_mc", s_mc, 3);

        // Stall with a pending opposite resolution
        drive(OP_BNEZ, 'h1F, 1'b0, 1'b0, 1'b0); tick();
        chk("stall_pred", s_pred, 1);
        for (int i = 0; i < 3; i++) begin
            drive(OP_NOP, 0, 1'b1, 1'b0, 1'b1); tick();
            chk("stall_mis_forced_low", s_mis, 0);
        end
        chk("stall_bc_frozen", s_bc, 4);
        chk("stall_mc_frozen", s_mc, 3);
        drive(OP_NOP, 0, 1'b1, 1'b0, 1'b0); tick();
        chk("stall_release_mis", s_mis, 1);
        drive(OP_NOP, 0, 1'b0, 1'b0, 1'b0); tick();
        chk("stall_release_bc", s_bc, 5);
        chk("stall_release_mc", s_mc, 4);
        chk("model_ghr_after_stall", 32'(m_ghr), 12);
        chk("model_pht17_after_stall", 32'(m_pht[17]), 1);

        // Entry saturation: five taken updates to entry 40
        for (int i = 0; i < 5; i++) begin
            drive(OP_BNEZ, 40 ^ m_ghr, 1'b0, 1'b0, 1'b0); tick();
            drive(OP_NOP, 0, 1'b1, 1'b1, 1'b0); tick();
        end
        chk("model_pht40_sat", 32'(m_pht[40]), 3);
        drive(OP_BNEZ, 40 ^ m_ghr, 1'b0, 1'b0, 1'b0); tick();
        chk("sat_pred_a", s_pred, 1);
        drive(OP_NOP, 0, 1'b1, 1'b0, 1'b0); tick();
        drive(OP_BNEZ, 40 ^ m_ghr, 1'b0, 1'b0, 1'b0); tick();
        chk("sat_pred_b", s_pred, 1);
        drive(OP_NOP, 0, 1'b0, 1'b0, 1'b0); tick();

        // Randomized traffic including stalls and occasional mid-run reset
        for (int i = 0; i < 3000; i++) begin
            op = ($urandom_range(0, 1) == 1) ? (OP_BEZ + 6'($urandom_range(0, 1))) : 6'($urandom);
            IF_Instr  = {op, 26'($urandom)};
            IF_PC     = 8'($urandom);
            Res_Valid = 1'($urandom_range(0, 1));
            Res_Taken = 1'($urandom_range(0, 1));
            IF_Hold   = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
            Reset     = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
            tick();
        end
        Reset = 1'b0;

        // Counter saturation at 15
        for (int i = 0; i < 20; i++) begin
            drive(OP_BEZ, $urandom_range(0, 255), 1'b0, 1'b0, 1'b0); tick();
            drive(OP_NOP, 0, 1'b1, 1'($urandom_range(0, 1)), 1'b0); tick();
        end
        drive(OP_NOP, 0, 1'b0, 1'b0, 1'b0); tick();
        chk("bc_saturated", s_bc, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
